mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Parametrised pipeline memory stage for the ARM core. It translates the ALU result into a word index relative to a configurable data-memory base and drives a multi-cycle data RAM through a wait-state FSM. A `ready` output stalls the pipeline for the duration of the access. Optional bounds checking flags accesses outside the mapped window. It sits between EX/MEM and MEM/WB and replaces the fixed single-cycle memory stage.

## Interface
- `DATA_W`, 32: data word width in bits.
- `DEPTH`, 64: number of data words; power of two, 2..4096.
- `BASE_ADDR`, 1024: byte address mapped to word 0.
- `ADDR_SHIFT`, 2: right shift applied to the address offset (log2 of bytes per word).
- `WAIT_CYCLES`, 3: extra access wait states, 0..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `Mem_R_EN`  in  1  read request; held stable until `ready`=1.
- `Mem_W_EN`  in  1  write request; held stable until `ready`=1.
- `ALU_res`  in  32  byte address.
- `Val_Rm`  in  DATA_W  store data.
- `data_mem`  out  DATA_W  registered load result.
- `ready`  out  1  stage can advance; stall the pipeline when 0.
- `addr_err`  out  1  out-of-window access flag; valid while `ready`=1.

## Operation
- Address arithmetic: offset = ALU_res − BASE_ADDR, computed 32-bit unsigned with wrap.
- Index = (offset >> ADDR_SHIFT)[log2(DEPTH)-1:0].
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - No request: `ready`=1 (combinational pass-through).
  - `Mem_R_EN|Mem_W_EN`=1: `ready`=0 in the same cycle; latch index, `Val_Rm` and op; load counter = WAIT_CYCLES; go to BUSY.
- BUSY: `ready`=0.
  - Counter ≠ 0: decrement.
  - Counter = 0: perform the access on this edge, then go to DONE.
  - Write: store the latched data into RAM at the latched index.
  - Read: load RAM[index] into `data_mem`.
- DONE: `ready`=1 for exactly one cycle, then go to IDLE unconditionally. A request still asserted in that cycle belongs to the current instruction and is not restarted.
- `Mem_R_EN` and `Mem_W_EN` both set: the write wins and `data_mem` is unchanged.
- `data_mem` holds the last load value until the next load completes.
- Inputs are sampled only on the IDLE→BUSY edge. Changes during BUSY are ignored.
- RAM contents are not cleared by `rst` and are undefined until written.

## Timing
- Reset values: state=IDLE, counter=0, `data_mem`=0, `addr_err`=0. `ready`=1 while no request is present.
- Request first presented in cycle 0: `ready` is low in cycles 0..WAIT_CYCLES+1 and high in cycle WAIT_CYCLES+2.
- Total stall is WAIT_CYCLES+2 cycles. With WAIT_CYCLES=0 the stall is 2 cycles.
- Load data is valid on `data_mem` from the DONE cycle onward.
- Back-to-back requests: the earliest next acceptance is the IDLE cycle after DONE.
- Asserting `rst` in BUSY aborts the access: a pending write is dropped and `data_mem` is forced to 0 asynchronously.

## Configuration
- Macro `MEM_STAGE_BOUNDS_CHECK_EN`.
  - Defined: the access is in-window iff offset < DEPTH<<ADDR_SHIFT (unsigned). Addresses below BASE_ADDR fail this test through the wrap.
  - Out-of-window write: dropped.
  - Out-of-window read: `data_mem` loaded with 0.
  - `addr_err`=1 during DONE, and 0 otherwise.
  - Undefined: the index wraps modulo DEPTH and `addr_err` is tied to 0. The port exists in both builds.

## Structure
- Package `mem_stage_pkg` holds:
  - the state enum `mem_state_t` (IDLE, BUSY, DONE);
  - the counter width constant (4 bits);
  - the helper function `addr_to_index`.
- Sub-module `data_ram`, parametrised by DATA_W and DEPTH:
  - synchronous write, registered synchronous read, no reset on the array;
  - controller FSM, counter and bounds check stay in `mem_stage_ctrl`.

## Test plan
- Reset then idle: `rst`=1 → `data_mem`=0, `ready`=1, `addr_err`=0; no request → `ready` stays 1.
- Store/load, defaults: write 0xDEADBEEF at ALU_res=1028, then read 1028.
  - Each access holds `ready`=0 for 5 cycles.
  - `data_mem`=0xDEADBEEF in the DONE cycle of the read.
- WAIT_CYCLES=0: write then read at 1024 with value 0x12345678 → 2-cycle stall each; readback 0x12345678.
- Simultaneous R/W at 1032 with prior `data_mem`=0xA5A5A5A5 → `data_mem` unchanged; a later read of 1032 returns the written value.
- Bounds, macro defined:
  - read ALU_res=1020 → `addr_err`=1 and `data_mem`=0 in DONE;
  - write at 1024+256 → `addr_err`=1 and word 0 is unchanged.
  - Macro undefined: a write at 1024+256 aliases to index 0.
- Reset mid-BUSY on a write of 0x55 to 1040 → state IDLE, `ready`=1; a later read of 1040 does not return 0x55 (pre-write 0x0 → 0x0).

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and address helper for the pipeline memory stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;

  localparam int CNT_W = 4;

  // Word offset from the mapped base; callers keep the low log2(DEPTH) bits.
  function automatic logic [31:0] addr_to_index(input logic [31:0] alu_res,
                                                input logic [31:0] base,
                                                input int unsigned shift);
    return (alu_res - base) >> shift;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_data_ram.sv
// Data RAM: synchronous write, registered read with async-clear output register.
module data_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     re,
  input  logic                     clr,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Only the read register is reset; the array keeps its contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      rdata <= '0;
    else if (clr) rdata <= '0;
    else if (re)  rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Multi-cycle memory stage: address translation, wait-state FSM, RAM control.
// Optional bounds check enabled by defining MEM_STAGE_BOUNDS_CHECK_EN.
//   state | meaning
//   IDLE  | waiting for a request; ready passes through as !request
//   BUSY  | counting wait states; access happens when counter hits 0
//   DONE  | one-cycle ready pulse, result valid on data_mem
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          ADDR_SHIFT  = 2,
  parameter int          WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Mem_R_EN,
  input  logic              Mem_W_EN,
  input  logic [31:0]       ALU_res,
  input  logic [DATA_W-1:0] Val_Rm,
  output logic [DATA_W-1:0] data_mem,
  output logic              ready,
  output logic              addr_err
);

  localparam int IDX_W = $clog2(DEPTH);

  mem_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic              rd_q;
  logic              oob_q;

  logic              req;
  logic [IDX_W-1:0]  idx_in;
  logic              oob_in;
  logic              access;

  assign req    = Mem_R_EN | Mem_W_EN;
  assign idx_in = IDX_W'(addr_to_index(ALU_res, BASE_ADDR, ADDR_SHIFT));

`ifdef MEM_STAGE_BOUNDS_CHECK_EN
  localparam logic [31:0] WINDOW = 32'(DEPTH) << ADDR_SHIFT;
  logic [31:0] offset;
  // Addresses below the base wrap to large offsets and fail this compare.
  assign offset = ALU_res - BASE_ADDR;
  assign oob_in = (offset >= WINDOW);
`else
  assign oob_in = 1'b0;
`endif

  assign ready  = ((state == IDLE) && !req) || (state == DONE);
  assign access = (state == BUSY) && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      oob_q    <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          addr_err <= 1'b0;
          if (req) begin
            idx_q   <= idx_in;
            wdata_q <= Val_Rm;
            wr_q    <= Mem_W_EN;
            rd_q    <= Mem_R_EN & ~Mem_W_EN;  // write wins on a combined request
            oob_q   <= oob_in;
            cnt     <= CNT_W'(WAIT_CYCLES);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            addr_err <= oob_q;
            state    <= DONE;
          end
        end
        DONE: begin
          addr_err <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  data_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (access & wr_q & ~oob_q),
    .re    (access & rd_q & ~oob_q),
    .clr   (access & rd_q & oob_q),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (data_mem)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized self-checking bench for mem_stage_ctrl against a word-array model.
`timescale 1ns/1ps
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  ren = '0;
  logic [1:0]  wen = '0;
  logic [31:0] alu [2];
  logic [31:0] val [2];
  logic [31:0] dmem [2];
  logic [1:0]  rdy;
  logic [1:0]  aerr;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [64];
  bit          mval [64];
  logic [31:0] mdm;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk(clk), .rst(rst), .Mem_R_EN(ren[0]), .Mem_W_EN(wen[0]),
    .ALU_res(alu[0]), .Val_Rm(val[0]), .data_mem(dmem[0]),
    .ready(rdy[0]), .addr_err(aerr[0])
  );

  mem_stage_ctrl #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .Mem_R_EN(ren[1]), .Mem_W_EN(wen[1]),
    .ALU_res(alu[1]), .Val_Rm(val[1]), .data_mem(dmem[1]),
    .ready(rdy[1]), .addr_err(aerr[1])
  );

  function automatic int m_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'((off / 4) % 64);
  endfunction

  function automatic bit m_oob(input logic [31:0] a);
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
    logic [31:0] off;
    off = a - 32'd1024;
    return off >= 32'd256;
`else
    return 1'b0;
`endif
  endfunction

  // Apply the spec's access rules to the word-array model for instance 0.
  task automatic model_apply(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (w) begin
      if (!m_oob(a)) begin
        mdl[m_idx(a)]  = d;
        mval[m_idx(a)] = 1'b1;
      end
    end else if (r) begin
      mdm = m_oob(a) ? 32'h0 : mdl[m_idx(a)];
    end
  endtask

  task automatic access(input int s, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, output int stall, output logic [31:0] dm,
                        output logic err);
    bit done;
    @(negedge clk);
    ren[s] = r; wen[s] = w; alu[s] = a; val[s] = d;
    stall = 0; done = 1'b0; dm = 'x; err = 1'bx;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (rdy[s]) begin
        dm = dmem[s]; err = aerr[s]; done = 1'b1;
        break;
      end
      stall++;
      // Address/data are not allowed to matter after acceptance.
      if (stall == 2) begin alu[s] = $urandom; val[s] = $urandom; end
      @(negedge clk);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_timeout inst=%0d addr=%h: ready never rose", s, a);
    end
    @(negedge clk);
    ren[s] = 1'b0; wen[s] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (dmem[s] !== 32'h0) begin errors++; $display("FAIL reset_data_mem inst=%0d got %h want 0", s, dmem[s]); end
      checks++;
      if (rdy[s] !== 1'b1) begin errors++; $display("FAIL reset_ready inst=%0d got %b want 1", s, rdy[s]); end
      checks++;
      if (aerr[s] !== 1'b0) begin errors++; $display("FAIL reset_addr_err inst=%0d got %b want 0", s, aerr[s]); end
    end
    @(negedge clk); rst = 1'b0;
    mdm = 32'h0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checks++;
      if (rdy !== 2'b11) begin errors++; $display("FAIL idle_ready got %b want 11", rdy); end
    end
  endtask

  task automatic test_store_load;
    int st; logic [31:0] dm; logic er;
    access(0, 0, 1, 32'd1028, 32'hDEADBEEF, st, dm, er);
    model_apply(0, 1, 32'd1028, 32'hDEADBEEF);
    checks++;
    if (st != 5) begin errors++; $display("FAIL store_stall got %0d want 5", st); end
    access(0, 1, 0, 32'd1028, 32'h0, st, dm, er);
    model_apply(1, 0, 32'd1028, 32'h0);
    checks++;
    if (st != 5) begin errors++; $display("FAIL load_stall got %0d want 5", st); end
    checks++;
    if (dm !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data got %h want deadbeef", dm); end
    #1;
    checks++;
    if (rdy[0] !== 1'b1) begin errors++; $display("FAIL post_done_ready got %b want 1", rdy[0]); end
    checks++;
    if (dmem[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL load_hold got %h want deadbeef", dmem[0]); end
  endtask

  task automatic test_wait0;
    int st; logic [31:0] dm; logic er;
    access(1, 0, 1, 32'd1024, 32'h12345678, st, dm, er);
    checks++;
    if (st != 2) begin errors++; $display("FAIL wait0_store_stall got %0d want 2", st); end
    access(1, 1, 0, 32'd1024, 32'h0, st, dm, er);
    checks++;
    if (st != 2) begin errors++; $display("FAIL wait0_load_stall got %0d want 2", st); end
    checks++;
    if (dm !== 32'h12345678) begin errors++; $display("FAIL wait0_load_data got %h want 12345678", dm); end
  endtask

  task automatic test_simultaneous;
    int st; logic [31:0] dm; logic er;
    access(0, 0, 1, 32'd1036, 32'hA5A5A5A5, st, dm, er);
    model_apply(0, 1, 32'd1036, 32'hA5A5A5A5);
    access(0, 1, 0, 32'd1036, 32'h0, st, dm, er);
    model_apply(1, 0, 32'd1036, 32'h0);
    access(0, 1, 1, 32'd1032, 32'h0BADF00D, st, dm, er);
    model_apply(1, 1, 32'd1032, 32'h0BADF00D);
    checks++;
    if (dm !== 32'hA5A5A5A5) begin errors++; $display("FAIL rw_data_unchanged got %h want a5a5a5a5", dm); end
    access(0, 1, 0, 32'd1032, 32'h0, st, dm, er);
    model_apply(1, 0, 32'd1032, 32'h0);
    checks++;
    if (dm !== 32'h0BADF00D) begin errors++; $display("FAIL rw_readback got %h want 0badf00d", dm); end
  endtask

  task automatic test_bounds;
    int st; logic [31:0] dm; logic er;
    logic [31:0] a_list [4];
    bit          w_list [4];
    logic [31:0] d_list [4];
    a_list = '{32'd1024, 32'd1276, 32'd1020, 32'd1280};
    w_list = '{1'b1, 1'b1, 1'b0, 1'b1};
    d_list = '{32'h11110000, 32'h6363_6363, 32'h0, 32'hCAFEF00D};
    for (int k = 0; k < 4; k++) begin
      access(0, !w_list[k], w_list[k], a_list[k], d_list[k], st, dm, er);
      model_apply(!w_list[k], w_list[k], a_list[k], d_list[k]);
      checks++;
      if (er !== m_oob(a_list[k])) begin errors++; $display("FAIL bounds_err addr=%0d got %b want %b", a_list[k], er, m_oob(a_list[k])); end
      if (!w_list[k]) begin
        checks++;
        if (dm !== mdm) begin errors++; $display("FAIL bounds_read addr=%0d got %h want %h", a_list[k], dm, mdm); end
      end
      #1;
      checks++;
      if (aerr[0] !== 1'b0) begin errors++; $display("FAIL bounds_err_clear got %b want 0", aerr[0]); end
    end
    access(0, 1, 0, 32'd1024, 32'h0, st, dm, er);
    model_apply(1, 0, 32'd1024, 32'h0);
    checks++;
    if (dm !== mdm) begin errors++; $display("FAIL bounds_word0 got %h want %h", dm, mdm); end
  endtask

  task automatic test_random;
    int st; logic [31:0] dm; logic er;
    int op; logic [31:0] a; logic [31:0] d;
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      access(0, 0, 1, 32'd1024 + 32'(4 * i), d, st, dm, er);
      model_apply(0, 1, 32'd1024 + 32'(4 * i), d);
    end
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) a = 32'd1024 - 32'(4 * $urandom_range(1, 8));
      else                           a = 32'd1024 + 32'(4 * $urandom_range(0, 79));
      d = $urandom;
      access(0, op != 1, op != 0, a, d, st, dm, er);
      model_apply(op != 1, op != 0, a, d);
      checks++;
      if (st != 5) begin errors++; $display("FAIL rand_stall i=%0d got %0d want 5", i, st); end
      checks++;
      if (er !== m_oob(a)) begin errors++; $display("FAIL rand_err i=%0d addr=%h got %b want %b", i, a, er, m_oob(a)); end
      checks++;
      if (dm !== mdm) begin errors++; $display("FAIL rand_data i=%0d addr=%h op=%0d got %h want %h", i, a, op, dm, mdm); end
    end
  endtask

  task automatic test_reset_busy;
    int st; logic [31:0] dm; logic er;
    access(0, 0, 1, 32'd1040, 32'h0, st, dm, er);
    model_apply(0, 1, 32'd1040, 32'h0);
    access(0, 1, 0, 32'd1028, 32'h0, st, dm, er);
    model_apply(1, 0, 32'd1028, 32'h0);
    @(negedge clk);
    wen[0] = 1'b1; alu[0] = 32'd1040; val[0] = 32'h55;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (rdy[0] !== 1'b0) begin errors++; $display("FAIL rb_busy_ready got %b want 0", rdy[0]); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (dmem[0] !== 32'h0) begin errors++; $display("FAIL rb_async_clear got %h want 0", dmem[0]); end
    wen[0] = 1'b0;
    mdm = 32'h0;
    @(negedge clk); rst = 1'b0;
    #1;
    checks++;
    if (rdy[0] !== 1'b1) begin errors++; $display("FAIL rb_ready got %b want 1", rdy[0]); end
    checks++;
    if (aerr[0] !== 1'b0) begin errors++; $display("FAIL rb_addr_err got %b want 0", aerr[0]); end
    access(0, 1, 0, 32'd1040, 32'h0, st, dm, er);
    model_apply(1, 0, 32'd1040, 32'h0);
    checks++;
    if (st != 5) begin errors++; $display("FAIL rb_restart_stall got %0d want 5", st); end
    checks++;
    if (dm !== mdm) begin errors++; $display("FAIL rb_dropped_write got %h want %h", dm, mdm); end
  endtask

  initial begin
    alu[0] = '0; alu[1] = '0; val[0] = '0; val[1] = '0;
    for (int i = 0; i < 64; i++) begin mdl[i] = '0; mval[i] = 1'b0; end
    mdm = '0;
    test_reset;
    test_store_load;
    test_wait0;
    test_simultaneous;
    test_bounds;
    test_random;
    test_reset_busy;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
